// File: rtl/register_file_param.sv
// Parameterised register file with one write port, three combinational read
// ports (A, B, D), optional hard-wired zero register, optional same-cycle
// write-to-read forwarding, and a per-register busy scoreboard.
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] PW,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              RDYA,
  output logic              RDYB,
  output logic              RDYD
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic              wr_ok;
  logic              set_ok;

  logic [ADDR_W-1:0] raddr [3];
  logic [DATA_W-1:0] rdata [3];
  logic              rdy   [3];

  // Register 0 swallows writes and busy marks when it is hard-wired to zero.
  assign wr_ok  = enable   && !((ZERO_REG != 0) && (RW == '0));
  assign set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

  // Scoreboard next state: a write retires the producer, a new busy mark on
  // the same edge is applied afterwards so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[RW]        = 1'b0;
    if (set_ok) busy_d[busy_addr] = 1'b1;
  end

  // Storage and scoreboard; reset clears everything without a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[RW] <= PW;
      busy_q <= busy_d;
    end
  end

  assign raddr[0] = RA;
  assign raddr[1] = RB;
  assign raddr[2] = RD;

  // Read ports: zero register first, then forwarding of the in-flight write,
  // then stored contents (forced to 0/ready while reset is held).
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      rdy[p]   = 1'b1;
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rdy[p]   = 1'b1;
      end else if ((BYPASS != 0) && enable && (raddr[p] == RW)) begin
        rdata[p] = PW;
        rdy[p]   = 1'b1;
      end else if (!reset_n) begin
        rdata[p] = '0;
        rdy[p]   = 1'b1;
      end else begin
        rdata[p] = regs_q[raddr[p]];
        rdy[p]   = ~busy_q[raddr[p]];
      end
    end
  end

  assign PA   = rdata[0];
  assign PB   = rdata[1];
  assign PD   = rdata[2];
  assign RDYA = rdy[0];
  assign RDYB = rdy[1];
  assign RDYD = rdy[2];

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default configuration, a
// forwarding-disabled copy sharing the same stimulus, and a narrow 16x8 copy.
module tb_register_file_param;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [4:0]  RW, RA, RB, RD, busy_addr;
  logic [31:0] PW;
  logic        busy_set;
  logic [31:0] PA, PB, PD;
  logic        RDYA, RDYB, RDYD;
  logic [31:0] nb_PA, nb_PB, nb_PD;
  logic        nb_RDYA, nb_RDYB, nb_RDYD;

  logic        s_enable, s_busy_set;
  logic [2:0]  s_RW, s_RA, s_RB, s_RD, s_busy_addr;
  logic [15:0] s_PW, s_PA, s_PB, s_PD;
  logic        s_RDYA, s_RDYB, s_RDYD;

  int tests_run = 0;
  int failed    = 0;

  register_file_param u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .RW(RW), .PW(PW),
    .RA(RA), .RB(RB), .RD(RD), .PA(PA), .PB(PB), .PD(PD),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .RDYA(RDYA), .RDYB(RDYB), .RDYD(RDYD)
  );

  register_file_param #(.BYPASS(0)) u_nb (
    .clock(clock), .reset_n(reset_n), .enable(enable), .RW(RW), .PW(PW),
    .RA(RA), .RB(RB), .RD(RD), .PA(nb_PA), .PB(nb_PB), .PD(nb_PD),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .RDYA(nb_RDYA), .RDYB(nb_RDYB), .RDYD(nb_RDYD)
  );

  register_file_param #(.DATA_W(16), .ADDR_W(3)) u_small (
    .clock(clock), .reset_n(reset_n), .enable(s_enable), .RW(s_RW), .PW(s_PW),
    .RA(s_RA), .RB(s_RB), .RD(s_RD), .PA(s_PA), .PB(s_PB), .PD(s_PD),
    .busy_set(s_busy_set), .busy_addr(s_busy_addr),
    .RDYA(s_RDYA), .RDYB(s_RDYB), .RDYD(s_RDYD)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_b, exp_d;
    int          jb, jd;

    reset_n = 1'b0; enable = 1'b0; RW = '0; PW = '0; RA = '0; RB = '0; RD = '0;
    busy_set = 1'b0; busy_addr = '0;
    s_enable = 1'b0; s_busy_set = 1'b0; s_RW = '0; s_PW = '0;
    s_RA = '0; s_RB = '0; s_RD = '0; s_busy_addr = '0;

    // Reset state
    #2;
    RA = 5'd3; RB = 5'd31; RD = 5'd0;
    #1;
    chk("rst_PA", PA, 32'h0);
    chk("rst_PB", PB, 32'h0);
    chk("rst_RDYA", 32'(RDYA), 32'h1);
    chk("rst_RDYB", 32'(RDYB), 32'h1);
    chk("rst_RDYD", 32'(RDYD), 32'h1);

    // Forwarding stays live during reset; the write itself is dropped
    enable = 1'b1; RW = 5'd2; PW = 32'h77; RA = 5'd2; busy_set = 1'b1; busy_addr = 5'd2;
    #1;
    chk("rst_bypass_PA", PA, 32'h77);
    chk("rst_nobypass_PA", nb_PA, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    enable = 1'b0; busy_set = 1'b0; reset_n = 1'b1;
    #1;
    chk("rst_write_dropped", PA, 32'h0);
    chk("rst_busy_dropped", 32'(RDYA), 32'h1);

    // Fill sweep R1..R31
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      enable = 1'b1; RW = 5'(i); PW = 32'(20 + i);
      RA = 5'(i); RB = 5'((i + 31) % 32); RD = 5'((i + 30) % 32);
      jb = (i + 31) % 32;
      jd = (i + 30) % 32;
      exp_b = (jb == 0 || jb >= i) ? 32'h0 : 32'(20 + jb);
      exp_d = (jd == 0 || jd >= i) ? 32'h0 : 32'(20 + jd);
      #1;
      chk($sformatf("fill_PA_%0d", i), PA, 32'(20 + i));
      chk($sformatf("fill_PB_%0d", i), PB, exp_b);
      chk($sformatf("fill_PD_%0d", i), PD, exp_d);
      chk($sformatf("fill_nbPA_%0d", i), nb_PA, 32'h0);
    end
    @(negedge clock);
    enable = 1'b0; RA = 5'd0; RB = 5'd31; RD = 5'd17;
    #1;
    chk("fill_R0", PA, 32'h0);
    chk("fill_R31", PB, 32'd51);
    chk("fill_R17", PD, 32'd37);
    chk("fill_nb_R31", nb_PB, 32'd51);

    // Zero register
    @(negedge clock);
    enable = 1'b1; RW = 5'd0; PW = 32'hDEADBEEF; RA = 5'd0; busy_set = 1'b1; busy_addr = 5'd0;
    #1;
    chk("zero_same_cycle", PA, 32'h0);
    chk("zero_rdy_same", 32'(RDYA), 32'h1);
    @(negedge clock);
    enable = 1'b0; busy_set = 1'b0;
    #1;
    chk("zero_after_edge", PA, 32'h0);
    chk("zero_rdy_after", 32'(RDYA), 32'h1);

    // Forwarding disabled: old value until the edge (R5 holds 25)
    @(negedge clock);
    enable = 1'b1; RW = 5'd5; PW = 32'h1234; RA = 5'd5;
    #1;
    chk("nb_old_value", nb_PA, 32'd25);
    chk("byp_new_value", PA, 32'h1234);
    @(negedge clock);
    enable = 1'b0;
    #1;
    chk("nb_after_edge", nb_PA, 32'h1234);

    // Scoreboard on R7 (holds 27)
    @(negedge clock);
    busy_set = 1'b1; busy_addr = 5'd7; RB = 5'd7;
    #1;
    chk("sb_not_yet_busy", 32'(RDYB), 32'h1);
    @(negedge clock);
    busy_set = 1'b0;
    #1;
    chk("sb_busy", 32'(RDYB), 32'h0);
    chk("sb_busy_data", PB, 32'd27);
    @(negedge clock);
    enable = 1'b1; RW = 5'd7; PW = 32'h55; RA = 5'd7; RD = 5'd7;
    #1;
    chk("sb_byp_RDYB", 32'(RDYB), 32'h1);
    chk("sb_byp_PB", PB, 32'h55);
    chk("sb_byp_PA", PA, 32'h55);
    chk("sb_byp_PD", PD, 32'h55);
    chk("sb_nb_RDYB", 32'(nb_RDYB), 32'h0);
    chk("sb_nb_PB", nb_PB, 32'd27);
    @(negedge clock);
    enable = 1'b0;
    #1;
    chk("sb_cleared", 32'(RDYB), 32'h1);
    chk("sb_stored", PB, 32'h55);
    @(negedge clock);
    enable = 1'b1; RW = 5'd7; PW = 32'h55; busy_set = 1'b1; busy_addr = 5'd7;
    @(negedge clock);
    enable = 1'b0; busy_set = 1'b0;
    #1;
    chk("sb_set_wins", 32'(RDYB), 32'h0);
    chk("sb_set_wins_data", PB, 32'h55);

    // Asynchronous reset mid-operation
    @(negedge clock);
    enable = 1'b1; RW = 5'd3; PW = 32'hFFFFFFFF; busy_set = 1'b1; busy_addr = 5'd4;
    @(negedge clock);
    enable = 1'b0; busy_set = 1'b0; RA = 5'd3; RB = 5'd4; RD = 5'd4;
    #1;
    chk("ar_loaded", PA, 32'hFFFFFFFF);
    chk("ar_busy", 32'(RDYB), 32'h0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("ar_PA_cleared", PA, 32'h0);
    chk("ar_RDYB", 32'(RDYB), 32'h1);
    chk("ar_RDYD", 32'(RDYD), 32'h1);
    enable = 1'b1; RW = 5'd9; PW = 32'h99; RA = 5'd9; busy_set = 1'b1; busy_addr = 5'd10; RB = 5'd10;
    #1;
    chk("ar_bypass_PA", PA, 32'h99);
    chk("ar_nb_PA", nb_PA, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    enable = 1'b0; busy_set = 1'b0; reset_n = 1'b1;
    #1;
    chk("ar_write_dropped", PA, 32'h0);
    chk("ar_busy_dropped", 32'(RDYB), 32'h1);
    @(negedge clock);
    enable = 1'b1; RW = 5'd9; PW = 32'h99;
    @(negedge clock);
    enable = 1'b0;
    #1;
    chk("ar_first_write", PA, 32'h99);

    // Narrow configuration: 16-bit data, 8 registers
    s_RA = 3'd7; s_RB = 3'd7; s_RD = 3'd7;
    #1;
    chk("small_initial", 32'(s_PA), 32'h0);
    @(negedge clock);
    s_enable = 1'b1; s_RW = 3'd7; s_PW = 16'hABCD;
    #1;
    chk("small_bypass", 32'(s_PA), 32'hABCD);
    @(negedge clock);
    s_enable = 1'b0;
    #1;
    chk("small_PA", 32'(s_PA), 32'hABCD);
    chk("small_PB", 32'(s_PB), 32'hABCD);
    chk("small_PD", 32'(s_PD), 32'hABCD);
    s_RA = 3'd6;
    #1;
    chk("small_R6", 32'(s_PA), 32'h0);
    chk("small_RDYB", 32'(s_RDYB), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
